// File: rtl/expipe_pkg.sv
// Execution pipeline shared types.
package expipe_pkg;

  typedef enum logic [2:0] {
    BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR
  } branch_ctl_t;

endpackage

// File: rtl/branch_resolve_unit.sv
// Single-cycle branch/jump resolution with an in-order frontend resolution
// queue, misprediction issue stall and saturating performance counters.
module branch_resolve_unit #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned ROB_IDX_W = 4,
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned C_EN      = 0,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  expipe_pkg::branch_ctl_t  branch_type_i,
  input  logic [XLEN-1:0]          rs1_i,
  input  logic [XLEN-1:0]          rs2_i,
  input  logic [XLEN-1:0]          imm_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          pred_target_i,
  input  logic                     pred_taken_i,
  input  logic                     compressed_i,
  input  logic [ROB_IDX_W-1:0]     rob_idx_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [ROB_IDX_W-1:0]     res_rob_idx_o,
  output logic [XLEN-1:0]          res_link_addr_o,
  output logic                     res_mispredicted_o,
  output logic                     res_except_o,
  output logic                     fe_res_valid_o,
  input  logic                     fe_res_ready_i,
  output logic [XLEN-1:0]          fe_res_pc_o,
  output logic [XLEN-1:0]          fe_res_target_o,
  output logic                     fe_res_taken_o,
  output logic                     fe_res_mispredict_o,
  output logic                     issue_mis_o,
  output logic [CNT_W-1:0]         perf_branches_o,
  output logic [CNT_W-1:0]         perf_mispred_o
);

  localparam int unsigned PTR_W  = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int unsigned CNT_QW = PTR_W + 1;

  typedef enum logic {RUN, WAIT_FE} state_t;

  state_t              state_q;
  logic                rdy_en_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_QW-1:0]   count_q;
  logic [XLEN-1:0]     q_pc_q     [RES_DEPTH];
  logic [XLEN-1:0]     q_target_q [RES_DEPTH];
  logic                q_taken_q  [RES_DEPTH];
  logic                q_mis_q    [RES_DEPTH];

  logic                taken_c, mispred_c, except_c;
  logic                accept_c, push_c, pop_c, full_c;
  logic [XLEN-1:0]     sum_c, target_c, link_c;

  // Branch condition evaluation
  always_comb begin
    taken_c = 1'b0;
    case (branch_type_i)
      expipe_pkg::BEQ:  taken_c = (rs1_i == rs2_i);
      expipe_pkg::BNE:  taken_c = (rs1_i != rs2_i);
      expipe_pkg::BLT:  taken_c = ($signed(rs1_i) <  $signed(rs2_i));
      expipe_pkg::BGE:  taken_c = ($signed(rs1_i) >= $signed(rs2_i));
      expipe_pkg::BLTU: taken_c = (rs1_i <  rs2_i);
      expipe_pkg::BGEU: taken_c = (rs1_i >= rs2_i);
      default:          taken_c = 1'b1;
    endcase
  end

  assign sum_c     = (branch_type_i == expipe_pkg::JALR) ? rs1_i + imm_i : pc_i + imm_i;
  assign target_c  = (branch_type_i == expipe_pkg::JALR) ? {sum_c[XLEN-1:1], 1'b0} : sum_c;
  assign link_c    = pc_i + (((C_EN != 0) && compressed_i) ? XLEN'(2) : XLEN'(4));
  assign mispred_c = (pred_taken_i != taken_c) | (pred_taken_i & (pred_target_i != target_c));
  // Misaligned taken target traps only when 16-bit instructions are not legal
  assign except_c  = (C_EN == 0) & taken_c & target_c[1];

  assign full_c         = (count_q == CNT_QW'(RES_DEPTH));
  assign ready_o        = rdy_en_q & (state_q == RUN) & ~flush_i &
                          (~res_valid_o | res_ready_i) & ~full_c;
  assign accept_c       = valid_i & ready_o;
  assign push_c         = accept_c & ~except_c;
  assign fe_res_valid_o = (count_q != '0);
  assign pop_c          = fe_res_valid_o & fe_res_ready_i;

  assign fe_res_pc_o         = q_pc_q[rd_ptr_q];
  assign fe_res_target_o     = q_target_q[rd_ptr_q];
  assign fe_res_taken_o      = q_taken_q[rd_ptr_q];
  assign fe_res_mispredict_o = q_mis_q[rd_ptr_q];
  assign issue_mis_o         = (state_q == WAIT_FE);

  // Accept enable rises one edge after reset release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdy_en_q <= 1'b0;
    else         rdy_en_q <= 1'b1;
  end

  // Misprediction stall FSM
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RUN;
    end else if (flush_i) begin
      state_q <= RUN;
    end else begin
      case (state_q)
        RUN:     if (push_c & mispred_c) state_q <= WAIT_FE;
        WAIT_FE: if (pop_c & fe_res_mispredict_o) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  // Frontend resolution queue
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < RES_DEPTH; i++) begin
        q_pc_q[i]     <= '0;
        q_target_q[i] <= '0;
        q_taken_q[i]  <= 1'b0;
        q_mis_q[i]    <= 1'b0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) begin
        q_pc_q[wr_ptr_q]     <= pc_i;
        q_target_q[wr_ptr_q] <= target_c;
        q_taken_q[wr_ptr_q]  <= taken_c;
        q_mis_q[wr_ptr_q]    <= mispred_c;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_QW'(1);
        2'b01:   count_q <= count_q - CNT_QW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Result register towards the reservation station
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_o        <= 1'b0;
      res_rob_idx_o      <= '0;
      res_link_addr_o    <= '0;
      res_mispredicted_o <= 1'b0;
      res_except_o       <= 1'b0;
    end else if (flush_i) begin
      res_valid_o <= 1'b0;
    end else if (accept_c) begin
      res_valid_o        <= 1'b1;
      res_rob_idx_o      <= rob_idx_i;
      res_link_addr_o    <= link_c;
      res_mispredicted_o <= mispred_c & ~except_c;
      res_except_o       <= except_c;
    end else if (res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

  // Saturating performance counters, preserved across flush
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_branches_o <= '0;
      perf_mispred_o  <= '0;
    end else begin
      if (accept_c && (perf_branches_o != '1))
        perf_branches_o <= perf_branches_o + CNT_W'(1);
      if (push_c && mispred_c && (perf_mispred_o != '1))
        perf_mispred_o <= perf_mispred_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized bench for branch_resolve_unit against a queue-based behavioural model.
module tb_branch_resolve_unit;
  import expipe_pkg::*;

  localparam int DEPTH = 4;
  localparam int CMAX  = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush, valid, ptaken, comp, res_ready, fe_ready;
  branch_ctl_t btype;
  logic [63:0] rs1, rs2, imm, pc, ptarget;
  logic [3:0]  rob;

  logic        ready_o, res_valid_o, res_mis_o, res_exc_o, fe_valid_o, fe_taken_o, fe_mis_o, issue_mis_o;
  logic [3:0]  res_rob_o, perf_br_o, perf_mp_o;
  logic [63:0] res_link_o, fe_pc_o, fe_target_o;

  logic        c_ready, c_res_valid, c_res_mis, c_res_exc, c_fe_valid, c_fe_taken, c_fe_mis, c_issue;
  logic [3:0]  c_res_rob;
  logic [31:0] c_perf_br, c_perf_mp;
  logic [63:0] c_res_link, c_fe_pc, c_fe_target;

  always #5 clk = ~clk;

  branch_resolve_unit #(.XLEN(64), .ROB_IDX_W(4), .RES_DEPTH(DEPTH), .C_EN(0), .CNT_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(ready_o),
    .branch_type_i(btype), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm), .pc_i(pc),
    .pred_target_i(ptarget), .pred_taken_i(ptaken), .compressed_i(comp), .rob_idx_i(rob),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready), .res_rob_idx_o(res_rob_o),
    .res_link_addr_o(res_link_o), .res_mispredicted_o(res_mis_o), .res_except_o(res_exc_o),
    .fe_res_valid_o(fe_valid_o), .fe_res_ready_i(fe_ready), .fe_res_pc_o(fe_pc_o),
    .fe_res_target_o(fe_target_o), .fe_res_taken_o(fe_taken_o), .fe_res_mispredict_o(fe_mis_o),
    .issue_mis_o(issue_mis_o), .perf_branches_o(perf_br_o), .perf_mispred_o(perf_mp_o));

  branch_resolve_unit #(.XLEN(64), .ROB_IDX_W(4), .RES_DEPTH(DEPTH), .C_EN(1), .CNT_W(32)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(c_ready),
    .branch_type_i(btype), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm), .pc_i(pc),
    .pred_target_i(ptarget), .pred_taken_i(ptaken), .compressed_i(comp), .rob_idx_i(rob),
    .res_valid_o(c_res_valid), .res_ready_i(res_ready), .res_rob_idx_o(c_res_rob),
    .res_link_addr_o(c_res_link), .res_mispredicted_o(c_res_mis), .res_except_o(c_res_exc),
    .fe_res_valid_o(c_fe_valid), .fe_res_ready_i(fe_ready), .fe_res_pc_o(c_fe_pc),
    .fe_res_target_o(c_fe_target), .fe_res_taken_o(c_fe_taken), .fe_res_mispredict_o(c_fe_mis),
    .issue_mis_o(c_issue), .perf_branches_o(c_perf_br), .perf_mispred_o(c_perf_mp));

  typedef struct { logic [63:0] pc; logic [63:0] tgt; bit tk; bit mis; } ent_t;
  ent_t mq[$];
  bit          m_rv, m_mis, m_exc, m_wait;
  logic [3:0]  m_rob;
  logic [63:0] m_link;
  int          m_br, m_mp;
  int          total = 0, passed = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  // Resolution rules for the C_EN=0 configuration
  function automatic void resolve(output bit tk, output logic [63:0] tgt, output bit mis, output bit exc);
    longint sa, sb;
    sa = longint'(rs1);
    sb = longint'(rs2);
    case (btype)
      BEQ:     tk = (rs1 == rs2);
      BNE:     tk = (rs1 != rs2);
      BLT:     tk = (sa < sb);
      BGE:     tk = (sa >= sb);
      BLTU:    tk = (rs1 < rs2);
      BGEU:    tk = (rs1 >= rs2);
      default: tk = 1'b1;
    endcase
    tgt = (btype == JALR) ? ((rs1 + imm) / 64'd2) * 64'd2 : pc + imm;
    mis = ptaken ? (!tk || ptarget != tgt) : tk;
    exc = tk && tgt[1];
  endfunction

  task automatic check_outputs();
    chk("res_valid", res_valid_o, m_rv);
    if (m_rv) begin
      chk("res_rob", res_rob_o, m_rob);
      chk("res_link", res_link_o, m_link);
      chk("res_mis", res_mis_o, m_mis);
      chk("res_exc", res_exc_o, m_exc);
    end
    chk("fe_valid", fe_valid_o, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("fe_pc", fe_pc_o, mq[0].pc);
      chk("fe_target", fe_target_o, mq[0].tgt);
      chk("fe_taken", fe_taken_o, mq[0].tk);
      chk("fe_mis", fe_mis_o, mq[0].mis);
    end
    chk("issue_mis", issue_mis_o, m_wait);
    chk("perf_br", 64'(perf_br_o), 64'(m_br));
    chk("perf_mp", 64'(perf_mp_o), 64'(m_mp));
  endtask

  // Inputs are already applied; check ready, advance model, clock, check registered outputs
  task automatic tick();
    bit exp_rdy, acc, tk, mis, exc;
    logic [63:0] tgt;
    ent_t e;
    #1;
    exp_rdy = !m_wait && !flush && (!m_rv || res_ready) && (mq.size() < DEPTH);
    chk("ready", ready_o, exp_rdy);
    acc = valid && exp_rdy;
    if (flush) begin
      mq.delete();
      m_rv = 0;
      m_wait = 0;
    end else begin
      if (mq.size() != 0 && fe_ready) begin
        e = mq.pop_front();
        if (e.mis) m_wait = 0;
      end
      if (acc) begin
        resolve(tk, tgt, mis, exc);
        m_rv = 1; m_rob = rob; m_link = pc + 64'd4; m_mis = mis && !exc; m_exc = exc;
        m_br = (m_br < CMAX) ? m_br + 1 : CMAX;
        if (!exc) begin
          mq.push_back('{pc: pc, tgt: tgt, tk: tk, mis: mis});
          if (mis) begin
            m_wait = 1;
            m_mp = (m_mp < CMAX) ? m_mp + 1 : CMAX;
          end
        end
      end else if (res_ready) begin
        m_rv = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    flush = 0; valid = 0; ptaken = 0; comp = 0; res_ready = 1; fe_ready = 1;
    btype = BEQ; rs1 = 0; rs2 = 0; imm = 0; pc = 0; ptarget = 0; rob = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    #1;
    chk("rst_ready", ready_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_fe_valid", fe_valid_o, 0);
    chk("rst_fe_pc", fe_pc_o, 0);
    chk("rst_issue", issue_mis_o, 0);
    chk("rst_perf_br", 64'(perf_br_o), 0);
    chk("rst_perf_mp", 64'(perf_mp_o), 0);
    mq.delete();
    m_rv = 0; m_wait = 0; m_br = 0; m_mp = 0; m_mis = 0; m_exc = 0; m_rob = 0; m_link = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_ready", ready_o, 1);
  endtask

  task automatic set_br(input branch_ctl_t t, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] p, input logic [63:0] i, input bit pt, input logic [63:0] ptg);
    valid = 1; btype = t; rs1 = a; rs2 = b; pc = p; imm = i; ptaken = pt; ptarget = ptg;
  endtask

  task automatic rand_inputs();
    bit tk, mis, exc;
    logic [63:0] tgt;
    valid     = ($urandom_range(0, 9) < 7);
    flush     = ($urandom_range(0, 99) < 3);
    res_ready = ($urandom_range(0, 9) < 7);
    fe_ready  = ($urandom_range(0, 9) < 5);
    btype     = branch_ctl_t'($urandom_range(0, 7));
    rs1       = {$urandom, $urandom};
    rs2       = $urandom_range(0, 1) ? rs1 : {$urandom, $urandom};
    pc        = {32'h0, $urandom} & ~64'd3;
    imm       = (64'($signed(14'($urandom))) & ~64'd3) | (($urandom_range(0, 3) == 0) ? 64'd2 : 64'd0);
    ptaken    = $urandom_range(0, 1);
    comp      = $urandom_range(0, 1);
    rob       = 4'($urandom);
    ptarget   = 0;
    resolve(tk, tgt, mis, exc);
    ptarget   = ($urandom_range(0, 9) < 6) ? tgt : {$urandom, $urandom};
  endtask

  int sv_br, sv_mp;

  initial begin
    idle();
    repeat (2) @(negedge clk);
    do_reset();

    // Correctly predicted BEQ
    set_br(BEQ, 64'd5, 64'd5, 64'h100, 64'h20, 1, 64'h120);
    fe_ready = 0;
    tick();
    chk("t1_mis", res_mis_o, 0);
    chk("t1_link", res_link_o, 64'h104);
    chk("t1_fe_taken", fe_taken_o, 1);
    chk("t1_fe_target", fe_target_o, 64'h120);
    chk("t1_perf_br", 64'(perf_br_o), 1);
    valid = 0; fe_ready = 1;
    tick();

    // Mispredicted BLT stalls until the frontend pops it
    set_br(BLT, '1, 64'd1, 64'h200, 64'h10, 0, 64'h0);
    fe_ready = 0;
    tick();
    chk("t2_mis", res_mis_o, 1);
    chk("t2_fe_mis", fe_mis_o, 1);
    chk("t2_issue", issue_mis_o, 1);
    chk("t2_perf_mp", 64'(perf_mp_o), 1);
    repeat (2) tick();
    chk("t2_stall_ready", ready_o, 0);
    valid = 0; fe_ready = 1;
    tick();
    chk("t2_issue_clr", issue_mis_o, 0);
    chk("t2_ready_back", ready_o, 1);

    // JALR to 0x2002: legal with compressed ISA, exception otherwise
    set_br(JALR, 64'h2003, 64'h0, 64'h40, 64'h0, 1, 64'h2002);
    comp = 1; fe_ready = 0;
    tick();
    chk("t3c_link", c_res_link, 64'h42);
    chk("t3c_exc", c_res_exc, 0);
    chk("t3c_fe_target", c_fe_target, 64'h2002);
    chk("t3_exc", res_exc_o, 1);
    chk("t3_fe_valid", fe_valid_o, 0);
    chk("t3_issue", issue_mis_o, 0);
    comp = 0; valid = 0; flush = 1;
    tick();
    flush = 0;

    // Fill the queue with the frontend stalled, then drain across pointer wrap
    fe_ready = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      set_br(JAL, 0, 0, 64'h1000 + 64'(4 * i), 64'h8, 1, 64'h1008 + 64'(4 * i));
      tick();
    end
    chk("t4_full_ready", ready_o, 0);
    chk("t4_head_pc", fe_pc_o, 64'h1000);
    fe_ready = 1;
    tick();
    chk("t4_ready_after_pop", ready_o, 1);
    chk("t4_head_pc2", fe_pc_o, 64'h1004);
    for (int i = 0; i < 6; i++) begin
      set_br(JAL, 0, 0, 64'h3000 + 64'(4 * i), 64'h8, 1, 64'h3008 + 64'(4 * i));
      tick();
    end
    valid = 0;
    repeat (6) tick();

    // Held result then back-to-back drain/accept
    res_ready = 0;
    set_br(JAL, 0, 0, 64'h500, 64'h8, 1, 64'h508);
    rob = 4'd3;
    tick();
    rob = 4'd5;
    tick();
    chk("t5_hold_rob", res_rob_o, 3);
    chk("t5_hold_ready", ready_o, 0);
    res_ready = 1;
    tick();
    chk("t5_b2b_rob", res_rob_o, 5);
    chk("t5_b2b_valid", res_valid_o, 1);
    valid = 0;
    tick();

    // Pending mispredict with two queued entries, then flush
    fe_ready = 0;
    set_br(JAL, 0, 0, 64'h600, 64'h8, 1, 64'h608); tick();
    set_br(JAL, 0, 0, 64'h604, 64'h8, 1, 64'h60c); tick();
    set_br(JAL, 0, 0, 64'h608, 64'h8, 0, 64'h0);   tick();
    chk("t6_issue", issue_mis_o, 1);
    sv_br = int'(perf_br_o);
    sv_mp = int'(perf_mp_o);
    flush = 1; valid = 1;
    tick();
    chk("t6_fe_valid", fe_valid_o, 0);
    chk("t6_res_valid", res_valid_o, 0);
    chk("t6_issue_clr", issue_mis_o, 0);
    chk("t6_perf_br", 64'(perf_br_o), 64'(sv_br));
    chk("t6_perf_mp", 64'(perf_mp_o), 64'(sv_mp));
    idle();
    tick();

    // Randomized traffic with an asynchronous reset in the middle
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        #3;
        do_reset();
      end
      rand_inputs();
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
